// File: rtl/cd_oven_mode_sequencer_pkg.sv
// Shared types for the Cd oven mode sequencer: FSM states, mode codes and
// a helper for counter widths.
package cd_oven_mode_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SEED,
    ST_RAMP,
    ST_LOCK,
    ST_FAULT
  } seq_state_e;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_99C  = 2'd1,
    MODE_119C = 2'd2,
    MODE_PROG = 2'd3
  } mode_e;

  // Counters must be at least one bit wide even for a modulus of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cd_oven_mode_sequencer_if.sv
// Mode request / setpoint bus between the display controller and the
// sequencer; the sequencer is the slave side.
interface cd_oven_mode_sequencer_if #(
  parameter int FILTER_IO_SIZE = 18
);
  logic        [1:0]                mode_req;
  logic signed [FILTER_IO_SIZE-1:0] sp_1;
  logic signed [FILTER_IO_SIZE-1:0] sp_2;
  logic signed [FILTER_IO_SIZE-1:0] sp_3;
  logic signed [FILTER_IO_SIZE-1:0] temp_in;
  logic signed [FILTER_IO_SIZE-1:0] shdn_thr;
  logic        [1:0]                mode_out;
  logic                             servo_en;
  logic signed [FILTER_IO_SIZE-1:0] sp_ramp;
  logic                             busy;
  logic                             fault;

  modport master (
    output mode_req, sp_1, sp_2, sp_3, temp_in, shdn_thr,
    input  mode_out, servo_en, sp_ramp, busy, fault
  );

  modport slave (
    input  mode_req, sp_1, sp_2, sp_3, temp_in, shdn_thr,
    output mode_out, servo_en, sp_ramp, busy, fault
  );
endinterface

// File: rtl/cd_oven_mode_sequencer_ramp_step.sv
// One rate-limited step of the setpoint toward its target; done flags that
// the target is within one step and may be taken directly.
module cd_sp_ramp_step #(
  parameter int FILTER_IO_SIZE = 18,
  parameter int STEP_SIZE      = 1
) (
  input  logic signed [FILTER_IO_SIZE-1:0] sp_ramp,
  input  logic signed [FILTER_IO_SIZE-1:0] tgt,
  output logic signed [FILTER_IO_SIZE-1:0] sp_next,
  output logic                             done
);
  localparam int MSB = FILTER_IO_SIZE - 1;
  localparam logic signed [FILTER_IO_SIZE:0]   STEP_W = (FILTER_IO_SIZE + 1)'(STEP_SIZE);
  localparam logic signed [FILTER_IO_SIZE-1:0] STEP_N = FILTER_IO_SIZE'(STEP_SIZE);

  // One bit wider so extreme setpoint/target pairs cannot wrap.
  logic signed [FILTER_IO_SIZE:0] diff;
  assign diff = {tgt[MSB], tgt} - {sp_ramp[MSB], sp_ramp};

  always_comb begin
    sp_next = tgt;
    done    = 1'b0;
    if (diff > STEP_W) begin
      sp_next = sp_ramp + STEP_N;
    end else if (diff < -STEP_W) begin
      sp_next = sp_ramp - STEP_N;
    end else begin
      done = 1'b1;
    end
  end
endmodule

// File: rtl/cd_oven_mode_sequencer.sv
// Sequences Cd oven servo mode changes: seeds the setpoint from the measured
// temperature, ramps it to the mode target and trips to a latched fault.
module cd_oven_mode_sequencer
  import cd_oven_mode_sequencer_pkg::*;
#(
  parameter int FILTER_IO_SIZE = 18,
  parameter int STEP_SIZE      = 1,
  parameter int STEP_DIV       = 10000,
  parameter int SETTLE_CYC     = 1000
) (
  input logic                     clk,
  input logic                     rst_n,
  cd_oven_mode_sequencer_if.slave bus
);
  localparam int W   = FILTER_IO_SIZE;
  localparam int SCW = cnt_width(SETTLE_CYC);
  localparam int DCW = cnt_width(STEP_DIV);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [DCW-1:0] STEP_LAST   = DCW'(STEP_DIV - 1);

  seq_state_e          state, state_nxt;
  logic [SCW-1:0]      settle_cnt, settle_nxt;
  logic [DCW-1:0]      step_cnt, step_nxt;
  logic [1:0]          mode_q, mode_nxt;
  logic signed [W-1:0] sp_q, sp_nxt, tgt, step_sp;
  logic                servo_q, servo_nxt, busy_q, busy_nxt, fault_q, fault_nxt;
  logic                step_done, over_temp, req_off, mode_chg;

  assign over_temp = (bus.temp_in >= bus.shdn_thr);
  assign req_off   = (bus.mode_req == MODE_OFF);
  assign mode_chg  = (bus.mode_req != mode_q);

  always_comb begin
    tgt = '0;
    case (mode_q)
      MODE_99C:  tgt = bus.sp_1;
      MODE_119C: tgt = bus.sp_2;
      MODE_PROG: tgt = bus.sp_3;
      default:   tgt = '0;
    endcase
  end

  cd_sp_ramp_step #(
    .FILTER_IO_SIZE(W),
    .STEP_SIZE     (STEP_SIZE)
  ) u_ramp_step (
    .sp_ramp(sp_q),
    .tgt    (tgt),
    .sp_next(step_sp),
    .done   (step_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      settle_cnt <= '0;
      step_cnt   <= '0;
      mode_q     <= '0;
      sp_q       <= '0;
      servo_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      step_cnt   <= step_nxt;
      mode_q     <= mode_nxt;
      sp_q       <= sp_nxt;
      servo_q    <= servo_nxt;
      busy_q     <= busy_nxt;
      fault_q    <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state != ST_FAULT && over_temp) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_OFF:   if (!req_off) state_nxt = ST_SEED;
        ST_SEED: begin
          if (req_off)                                      state_nxt = ST_OFF;
          else if (!mode_chg && settle_cnt == SETTLE_LAST)  state_nxt = ST_RAMP;
        end
        ST_RAMP: begin
          if (req_off)                                      state_nxt = ST_OFF;
          else if (mode_chg)                                state_nxt = ST_RAMP;
          else if (step_cnt == STEP_LAST && step_done)      state_nxt = ST_LOCK;
        end
        ST_LOCK: begin
          if (req_off)                                      state_nxt = ST_OFF;
          else if (mode_chg || !step_done)                  state_nxt = ST_RAMP;
        end
        ST_FAULT: if (req_off && !over_temp) state_nxt = ST_OFF;
        default:  state_nxt = ST_OFF;
      endcase
    end
  end

  // Registered outputs are decided from the destination state; seeding and
  // counter restarts key off whether this is a fresh entry or a mode change.
  always_comb begin
    mode_nxt   = mode_q;
    sp_nxt     = sp_q;
    settle_nxt = settle_cnt;
    step_nxt   = step_cnt;
    servo_nxt  = (state_nxt == ST_RAMP) || (state_nxt == ST_LOCK);
    busy_nxt   = (state_nxt == ST_SEED) || (state_nxt == ST_RAMP);
    fault_nxt  = (state_nxt == ST_FAULT);
    case (state_nxt)
      ST_SEED: begin
        mode_nxt = bus.mode_req;
        if (state != ST_SEED || mode_chg) begin
          sp_nxt     = bus.temp_in;
          settle_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + SCW'(1);
        end
      end
      ST_RAMP: begin
        mode_nxt = bus.mode_req;
        if (state != ST_RAMP || mode_chg) begin
          step_nxt = '0;
        end else if (step_cnt == STEP_LAST) begin
          step_nxt = '0;
          sp_nxt   = step_sp;
        end else begin
          step_nxt = step_cnt + DCW'(1);
        end
      end
      ST_LOCK: sp_nxt = step_sp;
      default: mode_nxt = MODE_OFF;
    endcase
  end

  assign bus.mode_out = mode_q;
  assign bus.servo_en = servo_q;
  assign bus.sp_ramp  = sp_q;
  assign bus.busy     = busy_q;
  assign bus.fault    = fault_q;

endmodule
